// File: rtl/node_seq_mac.sv
// node_seq_mac: time-multiplexed neuron node.
//
// Streams an N_IN-element float32 activation vector, multiplies each beat by a
// runtime-loadable weight and accumulates the products onto BIAS through one
// shared multiplier and one shared adder (one beat per cycle). The finished,
// optionally ReLU-clamped, sum is presented on a valid/ready output.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   w_wr_en/addr/data   weight RAM write port (addresses >= N_IN ignored)
//   in_valid/in_ready   activation stream handshake, in_data float32 beat,
//   in_data, in_last    in_last marks the sender's final beat
//   out_valid/out_ready result handshake, out_data float32 result
//   out_data
//   err_len             one-cycle pulse when in_last disagrees with the count
//   dbg_state           current FSM state (0 = ACC, 1 = DONE)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. A valid source holds its data until that edge; ready never depends
// combinationally on the opposite side's valid (in_ready is a function of the
// FSM state alone).
//
// Float arithmetic: IEEE-754 single precision, round-to-nearest-even.
// Subnormal inputs and results are flushed to signed zero; overflow goes to
// infinity; any NaN or invalid operation yields the quiet NaN 7FC00000.
module node_seq_mac #(
  parameter int          N_IN   = 15,
  parameter int          RELU   = 1,
  parameter logic [31:0] BIAS   = 32'h00000000,
  parameter logic [31:0] W_INIT = 32'hBE946670,
  localparam int         IW     = $clog2(N_IN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          w_wr_en,
  input  logic [IW-1:0] w_wr_addr,
  input  logic [31:0]   w_wr_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_data,
  output logic          err_len,
  output logic          dbg_state
);

  localparam logic [31:0] QNAN = 32'h7FC00000;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_DONE = 1'b1
  } state_e;

  // sig layout: [26] hidden one, [25:3] fraction, [2] guard, [1:0] round/sticky
  function automatic logic [31:0] round_pack(input logic sign,
                                             input logic signed [10:0] exp_in,
                                             input logic [26:0] sig);
    logic [24:0]        rnd;
    logic signed [10:0] e;
    logic               up;
    up  = sig[2] & ((|sig[1:0]) | sig[3]);
    rnd = {1'b0, sig[26:3]} + {24'd0, up};
    e   = exp_in;
    if (rnd[24]) begin
      e   = e + 11'sd1;
      rnd = rnd >> 1;
    end
    if (e >= 11'sd255)     round_pack = {sign, 8'hFF, 23'd0};
    else if (e <= 11'sd0)  round_pack = {sign, 31'd0};
    else                   round_pack = {sign, e[7:0], rnd[22:0]};
  endfunction

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic               sign;
    logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [47:0]        prod;
    logic signed [10:0] e;
    logic [26:0]        sig;
    sign   = a[31] ^ b[31];
    a_zero = (a[30:23] == 8'h00);
    b_zero = (b[30:23] == 8'h00);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    prod   = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e      = $signed({3'b000, a[30:23]}) + $signed({3'b000, b[30:23]}) - 11'sd127;
    // Product of two [1,2) significands lies in [1,4): renormalise on bit 47.
    if (prod[47]) begin
      e   = e + 11'sd1;
      sig = {prod[47:22], |prod[21:0]};
    end else begin
      sig = {prod[46:21], |prod[20:0]};
    end
    if (a_nan || b_nan)                         fmul = QNAN;
    else if ((a_inf && b_zero) || (b_inf && a_zero)) fmul = QNAN;
    else if (a_inf || b_inf)                    fmul = {sign, 8'hFF, 23'd0};
    else if (a_zero || b_zero)                  fmul = {sign, 31'd0};
    else                                        fmul = round_pack(sign, e, sig);
  endfunction

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    lzc27 = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (v[i]) lzc27 = 5'(26 - i);
    end
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0]        fa, fb, x, y;
    logic [26:0]        mx, my, my_sh, sig;
    logic [27:0]        s;
    logic [7:0]         d;
    logic [4:0]         lz;
    logic signed [10:0] e;
    fa = (a[30:23] == 8'h00) ? {a[31], 31'd0} : a;
    fb = (b[30:23] == 8'h00) ? {b[31], 31'd0} : b;
    // x always carries the larger magnitude, so the result takes its sign.
    if (fa[30:0] >= fb[30:0]) begin
      x = fa;
      y = fb;
    end else begin
      x = fb;
      y = fa;
    end
    d     = x[30:23] - y[30:23];
    mx    = {1'b1, x[22:0], 3'b000};
    my    = {1'b1, y[22:0], 3'b000};
    if (d >= 8'd27) begin
      my_sh = 27'd1;
    end else begin
      my_sh    = my >> d;
      my_sh[0] = my_sh[0] | (|(my & ~(27'h7FFFFFF << d)));
    end
    e   = $signed({3'b000, x[30:23]});
    sig = 27'd0;
    lz  = 5'd0;
    if (x[31] == y[31]) begin
      s = {1'b0, mx} + {1'b0, my_sh};
      if (s[27]) begin
        e   = e + 11'sd1;
        sig = {s[27:2], s[1] | s[0]};
      end else begin
        sig = s[26:0];
      end
    end else begin
      s   = {1'b0, mx} - {1'b0, my_sh};
      lz  = lzc27(s[26:0]);
      sig = s[26:0] << lz;
      e   = e - $signed({6'b000000, lz});
    end
    if ((fa[30:23] == 8'hFF && fa[22:0] != 23'd0) ||
        (fb[30:23] == 8'hFF && fb[22:0] != 23'd0))   fadd = QNAN;
    else if (x[30:23] == 8'hFF)
      fadd = (y[30:23] == 8'hFF && x[31] != y[31]) ? QNAN : x;
    else if (y[30:0] == 31'd0)
      fadd = (x[30:0] == 31'd0) ? {x[31] & y[31], 31'd0} : x;
    else if (s == 28'd0)                              fadd = 32'h00000000;
    else                                              fadd = round_pack(x[31], e, sig);
  endfunction

  // Weight RAM
  logic [31:0] w_q [N_IN];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_IN; i++) w_q[i] <= W_INIT;
    end else if (w_wr_en && ({{(32-IW){1'b0}}, w_wr_addr} < 32'(N_IN))) begin
      w_q[w_wr_addr] <= w_wr_data;
    end
  end

  // Control and accumulator
  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [31:0]   acc_q, acc_d;
  logic [31:0]   out_q, out_d;
  logic          err_q, err_d;

  logic [31:0]   prod, sum;
  logic          last_beat, accept;

  always_comb begin
    prod      = fmul(in_data, w_q[idx_q]);
    sum       = fadd((idx_q == '0) ? BIAS : acc_q, prod);
    last_beat = (idx_q == IW'(N_IN - 1));
    accept    = in_valid && (state_q == ST_ACC);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    out_d   = out_q;
    err_d   = 1'b0;
    unique case (state_q)
      ST_ACC: begin
        if (accept) begin
          acc_d = sum;
          // in_last only flags a mismatch; the count alone delimits vectors.
          err_d = (in_last != last_beat);
          if (last_beat) begin
            idx_d   = '0;
            state_d = ST_DONE;
            out_d   = ((RELU != 0) && sum[31]) ? 32'h00000000 : sum;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_ACC;
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ACC;
      idx_q   <= '0;
      acc_q   <= 32'h00000000;
      out_q   <= 32'h00000000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = (state_q == ST_DONE);
  assign out_data  = out_q;
  assign err_len   = err_q;
  assign dbg_state = state_q;

endmodule
